// File: rtl/mem_arbiter.sv
// Shared-DRAM arbiter: NUM_CORES cores share one DRAM port, round-robin (or fixed priority with MEM_ARBITER_FIXED_PRIO_EN).
// Latency: grant/DRAM drive registered one edge after request; read data returned READ_LATENCY edges after that.
// Backpressure: a core holds core_req until it sees its one-cycle grant; requests are only sampled while idle.
module mem_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             core_req,
    input  logic [NUM_CORES-1:0]             core_write,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_address,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_write_data,
    output logic [NUM_CORES-1:0]             core_grant,
    output logic [NUM_CORES-1:0]             core_read_valid,
    output logic [DATA_WIDTH-1:0]            core_read_data,
    output logic [ADDR_WIDTH-1:0]            DRAM_address,
    output logic [DATA_WIDTH-1:0]            DRAM_output_data,
    output logic                             write_DRAM,
    input  logic [DATA_WIDTH-1:0]            DRAM_input_data
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   we_q, we_d;

    logic                   any_req;
    logic [IDX_W-1:0]       win;
    // The read sample edge: straight out of ACCESS for single-cycle DRAM, else when the countdown expires.
    logic                   rd_done;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    // Lowest-index requester wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        any_req = |core_req;
        win     = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req[IDX_W'(i)]) win = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_CORES.
    always_comb begin
        any_req = |core_req;
        win     = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
            if (!found && core_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Pointer moves to the core after the winner on every grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && any_req) begin
            rr_ptr_d = (win == IDX_W'(NUM_CORES - 1)) ? '0 : win + 1'b1;
        end
    end

    // Round-robin pointer register; core 0 has first priority out of reset.
    always_ff @(posedge clock) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    // State register and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            grant_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            grant_q  <= grant_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    // Next-state logic: IDLE -> ACCESS -> (IDLE | RDWAIT -> IDLE).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (READ_LATENCY == 1) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Sample on the edge where the countdown reaches zero.
                if (cnt_q == CNT_W'(1)) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values: launch the DRAM access on grant, return read data on the sample edge.
    always_comb begin
        win_d    = win_q;
        grant_d  = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        if (state_q == IDLE && any_req) begin
            win_d   = win;
            grant_d = NUM_CORES'(1) << win;
            addr_d  = core_address[win*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = core_write_data[win*DATA_WIDTH +: DATA_WIDTH];
            we_d    = core_write[win];
        end
        if (rd_done) begin
            rdata_d  = DRAM_input_data;
            rvalid_d = NUM_CORES'(1) << win_q;
        end
    end

    assign core_grant       = grant_q;
    assign core_read_valid  = rvalid_q;
    assign core_read_data   = rdata_q;
    assign DRAM_address     = addr_q;
    assign DRAM_output_data = wdata_q;
    assign write_DRAM       = we_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-DRAM arbiter and the next-generation replacement for the single-processor MAR/MDR-to-DRAM path. It lets `NUM_CORES` processor cores share one DRAM port. Each core raises a request carrying an address, write flag and write data. The arbiter grants one core at a time, round-robin, drives the DRAM port, and returns read data to the winner with a one-cycle valid pulse. It sits between the processor cores and the DRAM at the top level.

## Interface
- `NUM_CORES`, 4, number of requesting cores (2..16)
- `ADDR_WIDTH`, 16, DRAM address width
- `DATA_WIDTH`, 8, DRAM data width
- `READ_LATENCY`, 1, cycles from address presented to `DRAM_input_data` valid (≥1)

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `core_req`  in  NUM_CORES  per-core request, held until granted
- `core_write`  in  NUM_CORES  per-core 1 = write, 0 = read
- `core_address`  in  NUM_CORES*ADDR_WIDTH  packed, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `core_write_data`  in  NUM_CORES*DATA_WIDTH  packed, same layout
- `core_grant`  out  NUM_CORES  one-hot, one-cycle pulse: request accepted
- `core_read_valid`  out  NUM_CORES  one-hot, one-cycle pulse: `core_read_data` valid for that core
- `core_read_data`  out  DATA_WIDTH  read data, shared by all cores
- `DRAM_address`  out  ADDR_WIDTH  DRAM address
- `DRAM_output_data`  out  DATA_WIDTH  DRAM write data
- `write_DRAM`  out  1  DRAM write strobe
- `DRAM_input_data`  in  DATA_WIDTH  DRAM read data

## Operation
- States:
  - IDLE: no transaction in progress.
  - ACCESS: DRAM address, data and strobe are being driven.
  - RDWAIT: waiting on DRAM read latency.
- IDLE: at an edge where any `core_req` bit is high, choose winner w.
  - Latch w's address and data into `DRAM_address` and `DRAM_output_data`.
  - Set `write_DRAM` to `core_write[w]`.
  - Set `core_grant` to (1<<w).
  - Go to ACCESS.
- Round-robin: search starts at `rr_ptr` and wraps modulo `NUM_CORES`. After each grant, `rr_ptr` = (w+1) mod `NUM_CORES`.
- ACCESS, write: clear `write_DRAM` and `core_grant`, return to IDLE.
- ACCESS, read: clear `core_grant`, load latency counter with `READ_LATENCY`-1, go to RDWAIT. When `READ_LATENCY`=1, skip the counter and go straight to the read-sample edge.
- RDWAIT: decrement the counter. At the edge where it is 0:
  - capture `DRAM_input_data` into `core_read_data`;
  - set `core_read_valid` to (1<<w);
  - go to IDLE.
- Requests are not sampled outside IDLE. A request held through ACCESS/RDWAIT is not double-granted, because the core must drop it after seeing its grant.
- `DRAM_address` and `DRAM_output_data` hold their last value between transactions. `core_read_data` holds until the next read completes.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - `rr_ptr` 0, so core 0 has first priority;
  - latency counter 0.
- Reset mid-transaction: the transaction is abandoned. No `core_read_valid` is pulsed and `write_DRAM` is 0 the next cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Request sampled at edge E0:
  - `core_grant`, `DRAM_address`, `DRAM_output_data` and `write_DRAM` are valid in cycle E0..E1.
  - A write strobe is exactly one cycle wide.
- Write occupancy: 2 edges. The next request can be sampled at E2.
- Read: `DRAM_input_data` is sampled at edge E0+`READ_LATENCY`. `core_read_valid` is high for the following cycle. The next request can be sampled at that same edge plus 1.
- Simultaneous requests: exactly one grant per transaction. Losers hold `core_req` and are served in round-robin order; with all cores requesting, each is served once per `NUM_CORES` transactions.
- Winner index width: $clog2(`NUM_CORES`), minimum 1 bit.

## Configuration
- `MEM_ARBITER_FIXED_PRIO_EN`
- Defined: fixed priority. The lowest-index requesting core always wins, and `rr_ptr` is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset, then a single read: core 2 reads 0x0040 with DRAM returning 0xA5 (`READ_LATENCY`=1). Expect `core_grant`=4'b0100 for one cycle, `DRAM_address`=0x0040, then `core_read_valid`=4'b0100 with `core_read_data`=0xA5 one cycle later; `write_DRAM` stays 0.
- Write: core 1 writes 0x3C to 0x1234. Expect `write_DRAM` high for exactly one cycle with `DRAM_address`=0x1234 and `DRAM_output_data`=0x3C; no `core_read_valid`.
- All four cores request reads together and hold them until granted. Expect grant order 0,1,2,3. Re-request cores 0 and 3: expect order 0,3. With the macro defined, expect 0,1,2,3 for the first batch and always core 0 first.
- `READ_LATENCY`=3: core 0 reads. Expect `core_read_valid` exactly 3 cycles after the grant cycle begins, and no new grant before then even with core 1 requesting.
- Assert `reset` in the cycle after a read grant. Expect no `core_read_valid`, all outputs 0 next cycle, and the next grant going to core 0.
